// File: rtl/sd_loader_pkg.sv
// Shared constants and FSM state type for the SD-card-to-SDRAM block loader.
package sd_loader_pkg;

    // SD card slave register word addresses; buffer words occupy 0..127
    localparam int SD_ADDR_CMD_ARG = 139;
    localparam int SD_ADDR_CMD     = 140;
    localparam int SD_ADDR_ASR     = 141;
    localparam int BUF_LAST_WORD   = 127;

    localparam logic [31:0] CMD_READ_BLOCK = 32'h11;

    // ASR status bits
    localparam int ASR_CARD_PRESENT = 1;
    localparam int ASR_IN_PROGRESS  = 2;
    localparam int ASR_CMD_TIMEOUT  = 3;
    localparam int ASR_CRC_FAIL     = 4;

    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_NO_CARD      = 2'd1;
    localparam logic [1:0] ERR_SD_CMD       = 2'd2;
    localparam logic [1:0] ERR_POLL_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK_CARD,
        S_WR_ARG,
        S_WR_CMD,
        S_POLL,
        S_RD_BUF,
        S_WR_LO,
        S_WR_HI,
        S_NEXT_BLK,
        S_DONE,
        S_ERR
    } state_t;

    // SD byte address of a 512-byte block, truncated to 32 bits
    function automatic logic [31:0] block_byte_addr(input logic [31:0] blk);
        return blk << 9;
    endfunction

endpackage

// File: rtl/sd_block_loader_if.sv
// Avalon-MM bus bundle: SD card slave port plus SDRAM controller s1 port.
interface sd_block_loader_if #(
    parameter int SD_AW    = 8,
    parameter int SDRAM_AW = 25
);
    logic                sd_chipselect;
    logic                sd_read;
    logic                sd_write;
    logic [SD_AW-1:0]    sd_address;
    logic [3:0]          sd_byteenable;
    logic [31:0]         sd_writedata;
    logic [31:0]         sd_readdata;
    logic                sd_waitrequest;

    logic                ram_chipselect;
    logic                ram_read_n;
    logic                ram_write_n;
    logic [1:0]          ram_byteenable_n;
    logic [SDRAM_AW-1:0] ram_address;
    logic [15:0]         ram_writedata;
    logic                ram_waitrequest;

    modport master (
        output sd_chipselect, sd_read, sd_write, sd_address, sd_byteenable, sd_writedata,
        input  sd_readdata, sd_waitrequest,
        output ram_chipselect, ram_read_n, ram_write_n, ram_byteenable_n, ram_address,
               ram_writedata,
        input  ram_waitrequest
    );

    modport slave (
        input  sd_chipselect, sd_read, sd_write, sd_address, sd_byteenable, sd_writedata,
        output sd_readdata, sd_waitrequest,
        input  ram_chipselect, ram_read_n, ram_write_n, ram_byteenable_n, ram_address,
               ram_writedata,
        output ram_waitrequest
    );

endinterface

// File: rtl/avmm_single_xfer.sv
// One outstanding Avalon-MM transfer: latches a request, holds the command until
// waitrequest drops, then pulses ack with the read data captured on that edge.
module avmm_single_xfer #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          av_chipselect,
    output logic          av_read,
    output logic          av_write,
    output logic [AW-1:0] av_address,
    output logic [DW-1:0] av_writedata,
    input  logic [DW-1:0] av_readdata,
    input  logic          av_waitrequest
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            av_chipselect <= 1'b0;
            av_read       <= 1'b0;
            av_write      <= 1'b0;
            ack           <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (av_chipselect) begin
                if (!av_waitrequest) begin
                    av_chipselect <= 1'b0;
                    av_read       <= 1'b0;
                    av_write      <= 1'b0;
                    ack           <= 1'b1;
                end
            end else if (req) begin
                av_chipselect <= 1'b1;
                av_read       <= !we;
                av_write      <= we;
            end
        end
    end

    // NOTE: address/data registers carry no reset; they are only observed while a strobe is up.
    always_ff @(posedge clk) begin
        if (!av_chipselect && req) begin
            av_address   <= addr;
            av_writedata <= wdata;
        end
        if (av_chipselect && !av_waitrequest) begin
            rdata <= av_readdata;
        end
    end

endmodule

// File: rtl/sd_block_loader.sv
// Copies num_blocks consecutive 512-byte SD blocks into SDRAM as 16-bit halfwords,
// starting at sdram_base; one start pulse runs the whole transfer.
module sd_block_loader
    import sd_loader_pkg::*;
#(
    parameter int          SD_AW        = 8,
    parameter int          SDRAM_AW     = 25,
    parameter logic [23:0] POLL_TIMEOUT = 24'hFFFFFF
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                start,
    input  logic [31:0]         start_block,
    input  logic [15:0]         num_blocks,
    input  logic [SDRAM_AW-1:0] sdram_base,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    sd_block_loader_if.master   bus
);

    state_t              state;
    logic                issued;
    logic                sd_req;
    logic                sd_we;
    logic [SD_AW-1:0]    sd_addr;
    logic [31:0]         sd_wdata;
    logic                sd_ack;
    logic [31:0]         sd_rdata;
    logic                ram_req;
    logic [15:0]         ram_wdata;
    logic                ram_ack;
    logic [15:0]         ram_rdata_unused;
    logic                ram_rd;
    logic                ram_wr;
    logic [SDRAM_AW-1:0] ram_ptr;
    logic [31:0]         blk;
    logic [15:0]         remaining;
    logic [6:0]          word;
    logic [31:0]         buf_word;
    logic [23:0]         poll_cnt;

    avmm_single_xfer #(.AW(SD_AW), .DW(32)) u_sd_xfer (
        .clk            (clk_clk),
        .rst            (reset_reset),
        .req            (sd_req),
        .we             (sd_we),
        .addr           (sd_addr),
        .wdata          (sd_wdata),
        .ack            (sd_ack),
        .rdata          (sd_rdata),
        .av_chipselect  (bus.sd_chipselect),
        .av_read        (bus.sd_read),
        .av_write       (bus.sd_write),
        .av_address     (bus.sd_address),
        .av_writedata   (bus.sd_writedata),
        .av_readdata    (bus.sd_readdata),
        .av_waitrequest (bus.sd_waitrequest)
    );

    avmm_single_xfer #(.AW(SDRAM_AW), .DW(16)) u_ram_xfer (
        .clk            (clk_clk),
        .rst            (reset_reset),
        .req            (ram_req),
        .we             (1'b1),
        .addr           (ram_ptr),
        .wdata          (ram_wdata),
        .ack            (ram_ack),
        .rdata          (ram_rdata_unused),
        .av_chipselect  (bus.ram_chipselect),
        .av_read        (ram_rd),
        .av_write       (ram_wr),
        .av_address     (bus.ram_address),
        .av_writedata   (bus.ram_writedata),
        .av_readdata    (16'h0000),
        .av_waitrequest (bus.ram_waitrequest)
    );

    assign bus.sd_byteenable    = 4'hF;
    assign bus.ram_byteenable_n = 2'b00;
    assign bus.ram_read_n       = ~ram_rd;
    assign bus.ram_write_n      = ~ram_wr;

    // Each bus state issues one request on entry (issued=0) and advances on its ack.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= S_IDLE;
            issued    <= 1'b0;
            sd_req    <= 1'b0;
            sd_we     <= 1'b0;
            sd_addr   <= '0;
            sd_wdata  <= '0;
            ram_req   <= 1'b0;
            ram_wdata <= '0;
            ram_ptr   <= '0;
            blk       <= '0;
            remaining <= '0;
            word      <= '0;
            buf_word  <= '0;
            poll_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            sd_req  <= 1'b0;
            ram_req <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        blk       <= start_block;
                        remaining <= num_blocks;
                        ram_ptr   <= sdram_base;
                        error     <= 1'b0;
                        err_code  <= ERR_NONE;
                        busy      <= 1'b1;
                        issued    <= 1'b0;
                        state     <= (num_blocks == 16'd0) ? S_DONE : S_CHK_CARD;
                    end
                end
                S_CHK_CARD: begin
                    if (!issued) begin
                        issued  <= 1'b1;
                        sd_req  <= 1'b1;
                        sd_we   <= 1'b0;
                        sd_addr <= SD_AW'(SD_ADDR_ASR);
                    end else if (sd_ack) begin
                        issued <= 1'b0;
                        if (!sd_rdata[ASR_CARD_PRESENT]) begin
                            err_code <= ERR_NO_CARD;
                            state    <= S_ERR;
                        end else begin
                            state <= S_WR_ARG;
                        end
                    end
                end
                S_WR_ARG: begin
                    if (!issued) begin
                        issued   <= 1'b1;
                        sd_req   <= 1'b1;
                        sd_we    <= 1'b1;
                        sd_addr  <= SD_AW'(SD_ADDR_CMD_ARG);
                        sd_wdata <= block_byte_addr(blk);
                    end else if (sd_ack) begin
                        issued <= 1'b0;
                        state  <= S_WR_CMD;
                    end
                end
                S_WR_CMD: begin
                    if (!issued) begin
                        issued   <= 1'b1;
                        sd_req   <= 1'b1;
                        sd_we    <= 1'b1;
                        sd_addr  <= SD_AW'(SD_ADDR_CMD);
                        sd_wdata <= CMD_READ_BLOCK;
                    end else if (sd_ack) begin
                        issued   <= 1'b0;
                        poll_cnt <= '0;
                        state    <= S_POLL;
                    end
                end
                S_POLL: begin
                    poll_cnt <= poll_cnt + 24'd1;
                    if (!issued) begin
                        issued  <= 1'b1;
                        sd_req  <= 1'b1;
                        sd_we   <= 1'b0;
                        sd_addr <= SD_AW'(SD_ADDR_ASR);
                    end else if (sd_ack) begin
                        issued <= 1'b0;
                        if (!sd_rdata[ASR_IN_PROGRESS]) begin
                            if (sd_rdata[ASR_CMD_TIMEOUT] || sd_rdata[ASR_CRC_FAIL]) begin
                                err_code <= ERR_SD_CMD;
                                state    <= S_ERR;
                            end else begin
                                word  <= '0;
                                state <= S_RD_BUF;
                            end
                        end else if (poll_cnt >= POLL_TIMEOUT) begin
                            // Timeout is judged only at an ack so no transfer is left in flight
                            err_code <= ERR_POLL_TIMEOUT;
                            state    <= S_ERR;
                        end
                    end
                end
                S_RD_BUF: begin
                    if (!issued) begin
                        issued  <= 1'b1;
                        sd_req  <= 1'b1;
                        sd_we   <= 1'b0;
                        sd_addr <= SD_AW'(word);
                    end else if (sd_ack) begin
                        issued   <= 1'b0;
                        buf_word <= sd_rdata;
                        state    <= S_WR_LO;
                    end
                end
                S_WR_LO: begin
                    if (!issued) begin
                        issued    <= 1'b1;
                        ram_req   <= 1'b1;
                        ram_wdata <= buf_word[15:0];
                    end else if (ram_ack) begin
                        issued  <= 1'b0;
                        ram_ptr <= ram_ptr + SDRAM_AW'(1);
                        state   <= S_WR_HI;
                    end
                end
                S_WR_HI: begin
                    if (!issued) begin
                        issued    <= 1'b1;
                        ram_req   <= 1'b1;
                        ram_wdata <= buf_word[31:16];
                    end else if (ram_ack) begin
                        issued  <= 1'b0;
                        ram_ptr <= ram_ptr + SDRAM_AW'(1);
                        if (word == 7'(BUF_LAST_WORD)) begin
                            state <= S_NEXT_BLK;
                        end else begin
                            word  <= word + 7'd1;
                            state <= S_RD_BUF;
                        end
                    end
                end
                S_NEXT_BLK: begin
                    blk       <= blk + 32'd1;
                    remaining <= remaining - 16'd1;
                    issued    <= 1'b0;
                    state     <= (remaining == 16'd1) ? S_DONE : S_WR_ARG;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_loader.sv
// Randomized bench for sd_block_loader: SD card and SDRAM slave models with random
// waitrequest, and a scoreboard of the halfword writes and CMD_ARG values each run must produce.
module tb_sd_block_loader;

    localparam int          SD_AW      = 8;
    localparam int          SDRAM_AW   = 25;
    localparam logic [23:0] POLL_LIMIT = 24'd200;

    logic                clk_clk     = 1'b0;
    logic                reset_reset = 1'b1;
    logic                start       = 1'b0;
    logic [31:0]         start_block = '0;
    logic [15:0]         num_blocks  = '0;
    logic [SDRAM_AW-1:0] sdram_base  = '0;
    logic                busy;
    logic                done;
    logic                error;
    logic [1:0]          err_code;

    sd_block_loader_if #(.SD_AW(SD_AW), .SDRAM_AW(SDRAM_AW)) bus ();

    sd_block_loader #(.SD_AW(SD_AW), .SDRAM_AW(SDRAM_AW), .POLL_TIMEOUT(POLL_LIMIT)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .start       (start),
        .start_block (start_block),
        .num_blocks  (num_blocks),
        .sdram_base  (sdram_base),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .bus         (bus)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] data;
    } ram_wr_t;

    ram_wr_t     exp_ram[$];
    logic [31:0] exp_arg[$];
    logic [31:0] arg_log[$];
    logic [24:0] ram_addr_log[$];
    logic [15:0] ram_mem[logic [24:0]];

    int          wait_pct     = 20;
    bit          card_present = 1'b1;
    bit          fault_next   = 1'b0;
    bit          stuck        = 1'b0;
    bit          fault_flag   = 1'b0;
    int          polls_left   = 0;
    logic [31:0] cur_arg      = '0;
    logic [31:0] cur_blk      = '0;
    int          ram_writes   = 0;
    int          cmd_writes   = 0;
    int          bus_cycles   = 0;
    int          done_pulses  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h, expected no such event", name, act);
    endtask

    // Content of buffer word w of SD block blk (block 0 is {w,~w})
    function automatic logic [31:0] sd_word(input logic [31:0] blk, input int w);
        logic [15:0] h;
        h = 16'(w) ^ {blk[7:0], 8'h00};
        return {h, ~h};
    endfunction

    task automatic sd_access();
        logic in_prog;
        if (bus.sd_read && !bus.sd_write) begin
            if (bus.sd_address == 8'd141) begin
                in_prog = stuck || (polls_left > 0);
                bus.sd_readdata = {27'b0, 1'b0, fault_flag && !in_prog, in_prog, card_present, 1'b0};
                if (polls_left > 0) polls_left--;
            end else if (bus.sd_address < 8'd128) begin
                bus.sd_readdata = sd_word(cur_blk, int'(bus.sd_address));
            end else begin
                fail("sd_read_addr", 64'(bus.sd_address));
            end
        end else if (bus.sd_write && !bus.sd_read) begin
            check("sd_byteenable", 64'(bus.sd_byteenable), 64'hF);
            if (bus.sd_address == 8'd139) begin
                arg_log.push_back(bus.sd_writedata);
                if (exp_arg.size() == 0) fail("unexpected_cmd_arg", 64'(bus.sd_writedata));
                else check("cmd_arg", 64'(bus.sd_writedata), 64'(exp_arg.pop_front()));
                cur_arg = bus.sd_writedata;
            end else if (bus.sd_address == 8'd140) begin
                cmd_writes++;
                check("cmd_code", 64'(bus.sd_writedata), 64'h11);
                cur_blk    = cur_arg >> 9;
                polls_left = $urandom_range(0, 3);
                fault_flag = fault_next;
            end else begin
                fail("sd_write_addr", 64'(bus.sd_address));
            end
        end else begin
            fail("sd_strobe", {62'b0, bus.sd_read, bus.sd_write});
        end
    endtask

    task automatic ram_access();
        ram_wr_t e;
        if (!bus.ram_write_n && bus.ram_read_n && bus.ram_byteenable_n == 2'b00) begin
            ram_writes++;
            ram_addr_log.push_back(bus.ram_address);
            ram_mem[bus.ram_address] = bus.ram_writedata;
            if (exp_ram.size() == 0) begin
                fail("unexpected_ram_write", {bus.ram_address, bus.ram_writedata});
            end else begin
                e = exp_ram.pop_front();
                check("ram_write", 64'({bus.ram_address, bus.ram_writedata}), 64'({e.addr, e.data}));
            end
        end else begin
            fail("ram_strobe", {60'b0, bus.ram_read_n, bus.ram_write_n, bus.ram_byteenable_n});
        end
    endtask

    // Slave models and scoreboard compare: a transfer whose waitrequest is low here
    // completes on the next rising edge.
    always @(negedge clk_clk) begin
        if (done) done_pulses++;
        if (bus.sd_chipselect || bus.ram_chipselect) bus_cycles++;
        bus.sd_waitrequest  = ($urandom_range(0, 99) < wait_pct);
        bus.ram_waitrequest = ($urandom_range(0, 99) < wait_pct);
        if (!reset_reset && bus.sd_chipselect && !bus.sd_waitrequest) sd_access();
        if (!reset_reset && bus.ram_chipselect && !bus.ram_waitrequest) ram_access();
    end

    // code 0 = success, 1 = no card, 2/3 = failure after the first command
    task automatic prepare(input logic [31:0] blk, input int n, input logic [24:0] base,
                           input logic [1:0] code);
        logic [24:0] a;
        logic [31:0] d;
        exp_ram.delete();
        exp_arg.delete();
        arg_log.delete();
        ram_addr_log.delete();
        if (code != 2'd1) begin
            for (int b = 0; b < ((code == 2'd0) ? n : 1); b++) exp_arg.push_back((blk + 32'(b)) << 9);
        end
        if (code == 2'd0) begin
            a = base;
            for (int b = 0; b < n; b++) begin
                for (int w = 0; w < 128; w++) begin
                    d = sd_word(blk + 32'(b), w);
                    exp_ram.push_back({a, d[15:0]});
                    a = a + 25'd1;
                    exp_ram.push_back({a, d[31:16]});
                    a = a + 25'd1;
                end
            end
        end
    endtask

    task automatic pulse_start(input logic [31:0] blk, input int n, input logic [24:0] base);
        start_block = blk;
        num_blocks  = 16'(n);
        sdram_base  = base;
        @(negedge clk_clk);
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("error_cleared", 64'(error), 64'd0);
    endtask

    task automatic run_xfer(input logic [31:0] blk, input int n, input logic [24:0] base,
                            input logic [1:0] code);
        int  ram0, cmd0, done0;
        bit  seen;
        prepare(blk, n, base, code);
        ram0  = ram_writes;
        cmd0  = cmd_writes;
        done0 = done_pulses;
        pulse_start(blk, n, base);
        seen = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            if (done || error) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_clk);
        end
        if (!seen) fail("completion_timeout", 64'(n));
        repeat (3) @(negedge clk_clk);
        check("busy_idle", 64'(busy), 64'd0);
        check("error_flag", 64'(error), 64'(code != 2'd0));
        check("err_code", 64'(err_code), 64'(code));
        check("done_pulses", 64'(done_pulses - done0), 64'(code == 2'd0));
        check("ram_write_count", 64'(ram_writes - ram0), 64'((code == 2'd0) ? 256 * n : 0));
        check("cmd_write_count", 64'(cmd_writes - cmd0),
              64'((code == 2'd0) ? n : ((code == 2'd1) ? 0 : 1)));
        check("ram_left", 64'(exp_ram.size()), 64'd0);
        check("arg_left", 64'(exp_arg.size()), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ram0;
        int bus0;
        bus.sd_waitrequest  = 1'b0;
        bus.ram_waitrequest = 1'b0;
        bus.sd_readdata     = '0;

        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_sd_strobes", 64'({bus.sd_chipselect, bus.sd_read, bus.sd_write}), 64'd0);
        check("rst_ram_strobes", 64'({bus.ram_chipselect, bus.ram_read_n, bus.ram_write_n}), 64'b011);

        // One block, block 5, base 0x100
        run_xfer(32'd5, 1, 25'h100, 2'd0);
        check("t1_arg", 64'(arg_log[0]), 64'h0000_0A00);
        check("t1_lo0", 64'(ram_mem[25'h100]), 64'hFAFF);
        check("t1_hi0", 64'(ram_mem[25'h101]), 64'h0500);
        check("t1_lo127", 64'(ram_mem[25'h1FE]), 64'hFA80);
        check("t1_hi127", 64'(ram_mem[25'h1FF]), 64'h057F);

        // Three blocks from block 0 with heavy random waitrequest
        wait_pct = 50;
        run_xfer(32'd0, 3, 25'h0, 2'd0);
        check("t2_arg0", 64'(arg_log[0]), 64'h000);
        check("t2_arg1", 64'(arg_log[1]), 64'h200);
        check("t2_arg2", 64'(arg_log[2]), 64'h400);
        check("t2_blk1_lo0", 64'(ram_mem[25'h100]), 64'hFEFF);
        wait_pct = 20;

        // No card
        card_present = 1'b0;
        run_xfer(32'd7, 2, 25'h40, 2'd1);
        card_present = 1'b1;

        // Command fault after completion, then a clean retry
        fault_next = 1'b1;
        run_xfer(32'd9, 1, 25'h0, 2'd2);
        fault_next = 1'b0;
        run_xfer(32'd9, 1, 25'h1000, 2'd0);

        // SDRAM address wrap
        run_xfer(32'd3, 1, 25'h1FF_FFFF, 2'd0);
        check("wrap_first", 64'(ram_addr_log[0]), 64'h1FF_FFFF);
        check("wrap_second", 64'(ram_addr_log[1]), 64'h0);

        // Zero blocks: done without bus traffic
        bus0 = bus_cycles;
        run_xfer(32'd11, 0, 25'h0, 2'd0);
        check("zero_blk_bus_idle", 64'(bus_cycles - bus0), 64'd0);

        // Poll never completes
        stuck = 1'b1;
        run_xfer(32'd2, 1, 25'h0, 2'd3);
        stuck = 1'b0;

        // Reset in the middle of the buffer copy
        prepare(32'd4, 2, 25'h3000, 2'd0);
        ram0 = ram_writes;
        pulse_start(32'd4, 2, 25'h3000);
        for (int c = 0; c < 5000 && (ram_writes - ram0) < 20; c++) @(negedge clk_clk);
        check("mid_reset_progress", 64'((ram_writes - ram0) >= 20), 64'd1);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        check("abort_sd_strobes", 64'({bus.sd_chipselect, bus.sd_read, bus.sd_write}), 64'd0);
        check("abort_ram_strobes", 64'({bus.ram_chipselect, bus.ram_read_n, bus.ram_write_n}), 64'b011);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        run_xfer(32'd4, 1, 25'h2000, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
